// File: rtl/elevator_pkg.sv
// Shared elevator types: floor indexing, door FSM states and the
// direction-resolver interface types.
package elevator_pkg;

  localparam int NUM_FLOORS_DEFAULT = 7;
  localparam int FLOOR_W            = 3;
  localparam int DWELL_W            = 8;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    CLOSE
  } door_state_e;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  typedef struct packed {
    logic   valid;
    dir_e   dir;
    floor_t target;
  } dir_cmd_t;

  function automatic logic floor_in_range(input floor_t floor, input int num_floors);
    return int'(floor) < num_floors;
  endfunction

endpackage

// File: rtl/elevator_dwell_timer.sv
// Door dwell down-counter: load has priority over counting, and the count
// parks at zero until reloaded.
module elevator_dwell_timer
  import elevator_pkg::*;
#(
  parameter int WIDTH = DWELL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/elevator_request_queue.sv
// Call-button request bitmap plus the door service FSM that consumes a
// pending call when the car stops at that floor.
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = NUM_FLOORS_DEFAULT,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  at_floor,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic                  stop_req,
  output logic                  door_open,
  output logic                  service_done,
  output logic                  req_reject
);

  door_state_e           state;
  door_state_e           next_state;
  floor_t                service_floor;
  logic [NUM_FLOORS-1:0] queue_next;
  logic                  req_in_range;
  logic                  cur_pending;
  logic                  go_open;
  logic                  svc_hit;
  logic                  timer_load;
  logic                  timer_zero;

  always_comb begin
    req_in_range = floor_in_range(req_floor, NUM_FLOORS);
    cur_pending  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if ((current_floor == FLOOR_W'(i)) && queue_status[i]) begin
        cur_pending = 1'b1;
      end
    end
    go_open = (state == IDLE) && at_floor && cur_pending;
    // A repeat call for the floor being served extends the dwell instead of queueing.
    svc_hit = (state == OPEN) && req_valid && (req_floor == service_floor);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go_open) next_state = OPEN;
      OPEN:    if (!svc_hit && timer_zero) next_state = CLOSE;
      CLOSE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The clear is applied after the set so a same-cycle request for the served floor is absorbed.
  always_comb begin
    queue_next = queue_status;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (req_valid && !svc_hit && (req_floor == FLOOR_W'(i))) begin
        queue_next[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (go_open && (current_floor == FLOOR_W'(i))) begin
        queue_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      queue_status  <= '0;
      service_floor <= '0;
      stop_req      <= 1'b0;
      door_open     <= 1'b0;
      service_done  <= 1'b0;
      req_reject    <= 1'b0;
    end else begin
      state        <= next_state;
      queue_status <= queue_next;
      if (go_open) begin
        service_floor <= current_floor;
      end
      stop_req     <= (next_state != IDLE);
      door_open    <= (next_state == OPEN);
      service_done <= (next_state == CLOSE);
      req_reject   <= req_valid && !req_in_range;
    end
  end

  assign timer_load = go_open || svc_hit;

  elevator_dwell_timer #(
    .WIDTH(DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (DWELL_W'(DWELL_CYCLES - 1)),
    .count_en   (state == OPEN),
    .zero       (timer_zero)
  );

endmodule

// File: tb/tb_elevator_request_queue.sv
// Randomized bench for elevator_request_queue against a cycle-count model
// of pending calls and door dwell, plus directed scenario checks.
module tb_elevator_request_queue;

  localparam int NF = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [2:0]    req_floor = '0;
  logic [2:0]    current_floor = '0;
  logic          at_floor = 1'b0;
  logic [NF-1:0] queue_status;
  logic          stop_req;
  logic          door_open;
  logic          service_done;
  logic          req_reject;

  int num_vectors = 0;
  int num_miscompares = 0;
  int open_seen = 0;
  int done_seen = 0;

  bit m_q[NF];
  int m_open_left = 0;
  bit m_close = 0;
  int m_svc = 0;
  bit m_reject = 0;

  always #5 clk = ~clk;

  elevator_request_queue #(
    .NUM_FLOORS   (NF),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .current_floor (current_floor),
    .at_floor      (at_floor),
    .queue_status  (queue_status),
    .stop_req      (stop_req),
    .door_open     (door_open),
    .service_done  (service_done),
    .req_reject    (req_reject)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [NF-1:0] modelQueue();
    logic [NF-1:0] bits;
    for (int i = 0; i < NF; i++) bits[i] = m_q[i];
    return bits;
  endfunction

  // Model: m_open_left counts door-open cycles still to come, including the current one.
  task automatic modelStep(input bit r, input bit v, input int f, input int c, input bit a);
    bit go;
    if (r) begin
      for (int i = 0; i < NF; i++) m_q[i] = 0;
      m_open_left = 0;
      m_close = 0;
      m_svc = 0;
      m_reject = 0;
      return;
    end
    m_reject = v && (f >= NF);
    if (m_close) begin
      m_close = 0;
      if (v && f < NF) m_q[f] = 1;
    end else if (m_open_left > 0) begin
      if (v && f == m_svc) begin
        m_open_left = DW;
      end else begin
        if (v && f < NF) m_q[f] = 1;
        m_open_left--;
        if (m_open_left == 0) m_close = 1;
      end
    end else begin
      go = a && (c < NF) && m_q[c];
      if (v && f < NF) m_q[f] = 1;
      if (go) begin
        m_q[c] = 0;
        m_svc = c;
        m_open_left = DW;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input int f, input int c, input bit a);
    @(negedge clk);
    rst           = r;
    req_valid     = v;
    req_floor     = 3'(f);
    current_floor = 3'(c);
    at_floor      = a;
    @(posedge clk);
    modelStep(r, v, f, c, a);
    #1;
    checkOutput("queue_status", 32'(queue_status), 32'(modelQueue()));
    checkOutput("stop_req", 32'(stop_req), 32'((m_open_left > 0) || m_close));
    checkOutput("door_open", 32'(door_open), 32'(m_open_left > 0));
    checkOutput("service_done", 32'(service_done), 32'(m_close));
    checkOutput("req_reject", 32'(req_reject), 32'(m_reject));
    open_seen += int'(door_open);
    done_seen += int'(service_done);
  endtask

  initial begin
    bit r, v, a;
    int f, c;

    applyStimulus(1, 1, 2, 0, 0);
    applyStimulus(1, 1, 4, 4, 1);
    checkOutput("reset_queue", 32'(queue_status), 32'h0);

    applyStimulus(0, 1, 3, 0, 0);
    checkOutput("single_req_queue", 32'(queue_status), 32'h08);
    checkOutput("single_req_stop", 32'(stop_req), 32'h0);

    open_seen = 0;
    done_seen = 0;
    applyStimulus(0, 0, 0, 3, 1);
    checkOutput("service_clear_bit3", 32'(queue_status[3]), 32'h0);
    repeat (15) applyStimulus(0, 0, 0, 3, 0);
    checkOutput("dwell_open_cycles", 32'(open_seen), 32'd8);
    checkOutput("dwell_done_pulses", 32'(done_seen), 32'd1);

    applyStimulus(0, 1, 3, 0, 0);
    open_seen = 0;
    applyStimulus(0, 0, 0, 3, 1);
    repeat (4) applyStimulus(0, 0, 0, 3, 0);
    applyStimulus(0, 1, 3, 3, 0);
    checkOutput("extend_bit3_clear", 32'(queue_status[3]), 32'h0);
    repeat (15) applyStimulus(0, 0, 0, 3, 0);
    checkOutput("extend_open_cycles", 32'(open_seen), 32'd13);

    applyStimulus(0, 1, 7, 0, 0);
    checkOutput("reject_pulse", 32'(req_reject), 32'h1);
    checkOutput("reject_queue", 32'(queue_status), 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reject_one_cycle", 32'(req_reject), 32'h0);

    applyStimulus(0, 1, 5, 0, 0);
    applyStimulus(0, 1, 5, 5, 1);
    applyStimulus(0, 1, 1, 5, 1);
    checkOutput("absorb_bit5", 32'(queue_status[5]), 32'h0);
    checkOutput("absorb_bit1", 32'(queue_status[1]), 32'h1);
    repeat (12) applyStimulus(0, 0, 0, 5, 0);

    applyStimulus(0, 1, 6, 0, 0);
    applyStimulus(0, 1, 4, 0, 0);
    applyStimulus(0, 0, 0, 4, 1);
    checkOutput("pre_reset_queue", 32'(queue_status), 32'h42);
    checkOutput("pre_reset_door", 32'(door_open), 32'h1);
    applyStimulus(0, 0, 0, 4, 0);
    applyStimulus(1, 1, 2, 4, 1);
    checkOutput("open_reset_queue", 32'(queue_status), 32'h0);
    checkOutput("open_reset_outs", 32'({stop_req, door_open, service_done, req_reject}), 32'h0);
    applyStimulus(0, 0, 0, 4, 0);
    checkOutput("post_reset_idle", 32'(stop_req), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 1) == 1);
      if ((m_open_left > 0) && ($urandom_range(0, 3) == 0)) f = m_svc;
      else f = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      a = ($urandom_range(0, 2) != 0);
      applyStimulus(r, v, f, c, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/elevator_request_queue.md
ELEVATOR_REQUEST_QUEUE -- requirements
Module: elevator_request_queue

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 7: number of serviced floors, sets queue width.
REQ-002 SHALL have parameter DWELL_CYCLES, default 8: door-open dwell length in clock cycles, legal range 2..255.
REQ-003 SHALL have port clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  one-cycle call-button request strobe.
REQ-006 SHALL have port req_floor  input  3  floor index of the request, qualified by req_valid.
REQ-007 SHALL have port current_floor  input  3  floor the car is at or passing.
REQ-008 SHALL have port at_floor  input  1  car aligned with current_floor and able to stop.
REQ-009 SHALL have port queue_status  output  NUM_FLOORS  pending-call bitmap, bit n = floor n; this is the producer side of the queue consumed by the direction resolver.
REQ-010 SHALL have port stop_req  output  1  car must hold at current_floor.
REQ-011 SHALL have port door_open  output  1  door-open command.
REQ-012 SHALL have port service_done  output  1  one-cycle pulse when a floor's service completes.
REQ-013 SHALL have port req_reject  output  1  one-cycle pulse for an out-of-range request.

Function
REQ-014 SHALL set queue_status[req_floor] on the clock edge after req_valid=1 with req_floor < NUM_FLOORS; all other bits unchanged.
REQ-015 SHALL ignore req_valid with req_floor >= NUM_FLOORS, leave queue_status unchanged, and pulse req_reject for exactly one cycle in the following cycle.
REQ-016 SHALL treat a request for an already-set floor as a no-op, without an error or a pulse.
REQ-017 SHALL implement FSM states IDLE, OPEN and CLOSE.
REQ-018 IDLE SHALL go to OPEN when at_floor=1 and queue_status[current_floor]=1; otherwise it SHALL stay in IDLE.
REQ-019 On the IDLE->OPEN edge, the block SHALL clear queue_status[current_floor] and latch current_floor as the service floor.
REQ-020 On the IDLE->OPEN edge, the block SHALL load the dwell counter with DWELL_CYCLES-1.
REQ-021 OPEN SHALL decrement the counter each cycle and go to CLOSE on the cycle the counter reads 0, so door_open is high for exactly DWELL_CYCLES cycles.
REQ-022 While in OPEN, a valid request for the latched service floor SHALL reload the counter to DWELL_CYCLES-1 and SHALL NOT set its queue bit.
REQ-023 CLOSE SHALL last one cycle, pulse service_done, then return to IDLE.
REQ-024 In CLOSE, a request for the service floor SHALL set its queue bit normally.
REQ-025 stop_req SHALL be 1 in OPEN and CLOSE and 0 in IDLE; door_open SHALL be 1 only in OPEN; both SHALL be registered outputs.
REQ-026 If a request for floor X arrives in the same cycle that X is cleared on the IDLE->OPEN edge, the clear SHALL win and the request SHALL be absorbed; requests for other floors in that cycle SHALL set normally.
REQ-027 Requests for floors other than the service floor SHALL be accepted in every state.
REQ-028 Changes on current_floor or at_floor during OPEN or CLOSE SHALL be ignored.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL clear queue_status, enter IDLE, zero the dwell counter, and drive stop_req, door_open, service_done and req_reject to 0, regardless of the current state.
REQ-030 A request strobed in the same cycle as rst=1 SHALL be discarded.

Structure
REQ-031 NUM_FLOORS default, the floor-index width (3) and the FSM state enum SHALL live in a shared elevator package, alongside the types used by elevator_direction_resolver.
REQ-032 The dwell counter SHALL be a sub-module, elevator_dwell_timer, with load, count-down and zero-flag behaviour; queue and FSM logic SHALL stay in the top module.

Verification
REQ-033 Reset, then strobe req_floor=3 -> queue_status=7'b0001000 one cycle later; stop_req=0 and door_open=0.
REQ-034 With queue_status=7'b0001000, drive current_floor=3 and at_floor=1 -> queue bit 3 clears next edge, door_open high 8 cycles, one cycle of stop_req=1 with door_open=0, service_done pulses once, then IDLE.
REQ-035 Strobe req_floor=3 at door-open cycle 5 -> dwell restarts, door_open high 13 cycles in total, queue_status bit 3 stays 0.
REQ-036 Strobe req_floor=7 -> req_reject pulses one cycle, queue_status unchanged.
REQ-037 Floor 5 pending and car at_floor at floor 5; strobe req_floor=5 and req_floor=1 on that edge sequence -> bit 5 clear (absorbed), bit 1 set.
REQ-038 Assert rst during OPEN with queue_status=7'b1000010 -> next cycle all outputs 0, IDLE.
